ras_ctrl: RTL and testbench
===========================

Name: ras_ctrl

Overview:
Speculation controller for the return address stack (RAS) in the fetch frontend. It turns decoded call/return hints into RAS push/pop/push-and-pop commands and returns the predicted return target to fetch. It logs every speculative RAS operation since the last commit. On a pipeline flush it unwinds the RAS by replaying inverse operations, newest first, one per cycle, stalling decode until the RAS matches its committed state.

Parameters:
XLEN, 32, address width (from riscv_pkg)
LOG_DEPTH, 8, maximum uncommitted call/return operations held in the speculation log
LOG_PTR_WIDTH, 3, log index width; equals log2(LOG_DEPTH)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
dec_valid  input  1  decode slot holds a valid instruction
dec_is_call  input  1  instruction is a call (writes link register)
dec_is_ret  input  1  instruction is a return (jalr through link register)
dec_link_addr  input  XLEN  return address to push for a call (pc+4)
dec_ready  output  1  controller accepts a call/return this cycle
commit_valid  input  1  the oldest logged call/return has retired
flush  input  1  pipeline flush; every uncommitted logged operation is wrong-path
ras_push  output  1  RAS push command
ras_pop  output  1  RAS pop command (both high means push-and-pop, replace top)
ras_return_addr  output  XLEN  data for a RAS push or replace
ras_predicted_return  input  XLEN  current RAS top
ras_valid  input  1  RAS non-empty
pred_target  output  XLEN  predicted return target to fetch
pred_valid  output  1  pred_target usable
busy  output  1  controller is in UNWIND
log_count  output  LOG_PTR_WIDTH+1  number of uncommitted logged operations

Behaviour:
- Reset (async): state=IDLE, log head=tail=0, log_count=0. All command outputs are combinational and deassert with state. dec_ready=1 after reset release. The RAS shares the same reset.
- FSM states: IDLE, UNWIND.
- dec_ready = (state==IDLE) & !flush & (log_count < LOG_DEPTH).
- accept = dec_valid & dec_ready & (dec_is_call | dec_is_ret). Non-call/return instructions never stall and never log.
- On accept, commands are combinational in the same cycle and the RAS samples them on the same edge:
  - call only: ras_push=1, ras_return_addr=dec_link_addr; log {PUSH}.
  - ret only: ras_pop=1; log {POP, saved=ras_predicted_return, sv=ras_valid}.
  - call and ret: ras_push=ras_pop=1, ras_return_addr=dec_link_addr; log {PNP, saved=ras_predicted_return, sv=ras_valid}.
- pred_valid = dec_valid & dec_is_ret & ras_valid & (state==IDLE); pred_target = ras_predicted_return, else 0.
- commit_valid: pops the oldest entry (head++). It is accepted only in IDLE with log_count>0; otherwise it is ignored.
- Same-cycle accept and commit: log_count is unchanged; head and tail both advance.
- Flush in IDLE:
  - Any commit in the same cycle is applied first.
  - Decode is not accepted that cycle.
  - If the remaining log_count>0, go to UNWIND next cycle; otherwise stay in IDLE.
- UNWIND, one entry per cycle, taken from tail-1 (newest first):
  - PUSH: ras_pop=1.
  - POP with sv=1: ras_push=1, ras_return_addr=saved.
  - PNP with sv=1: ras_push=ras_pop=1, ras_return_addr=saved.
  - POP or PNP with sv=0: no RAS command is issued, but the cycle is still consumed.
  - Each cycle: tail--, log_count--.
  - When the entry with log_count==1 is processed, return to IDLE next cycle.
  - An N-entry unwind takes exactly N cycles with busy=1.
- In UNWIND, flush, commit_valid and dec_valid are ignored; dec_ready=0 and pred_valid=0.
- Pointer wrap: head and tail wrap modulo LOG_DEPTH.
- Full log (log_count==LOG_DEPTH): dec_ready=0 until a commit arrives.
- RAS overflow: a push into a full RAS overwrites the oldest entry. Unwind cannot restore that entry; this is accepted imprecision and is not an error.
- Reset mid-UNWIND: immediate return to IDLE with the log cleared.

Test Plan:
- Call with link 0x100, then call with link 0x200, then flush -> ras_pop high for 2 consecutive cycles, busy=1 for 2 cycles, then RAS empty, log_count=0, dec_ready=1.
- Call with link 0x100 committed; ret speculative with pred_target=0x100, pred_valid=1; flush -> 1-cycle unwind with ras_push=1, ras_return_addr=0x100.
- Ret on empty RAS (pred_valid=0), then flush -> 1 UNWIND cycle with no RAS command; IDLE afterwards.
- 8 uncommitted calls -> dec_ready=0 and a 9th call stalls; commit_valid -> log_count=7 and the 9th call is accepted the next cycle.
- Tail call (call and ret) with link 0x300 over top 0x100, then flush -> ras_push=ras_pop=1 with ras_return_addr=0x100 in unwind.
- Assert reset in the 2nd cycle of a 4-entry unwind -> busy=0, log_count=0 immediately; dec_ready=1 after reset release.

Source files
------------

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - RAS speculation log with newest-first flush unwind
module ras_ctrl #(
   parameter int XLEN          = 32,
   parameter int LOG_DEPTH     = 8,
   parameter int LOG_PTR_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dec_valid,
   input  logic                     dec_is_call,
   input  logic                     dec_is_ret,
   input  logic [XLEN-1:0]          dec_link_addr,
   output logic                     dec_ready,
   input  logic                     commit_valid,
   input  logic                     flush,
   output logic                     ras_push,
   output logic                     ras_pop,
   output logic [XLEN-1:0]          ras_return_addr,
   input  logic [XLEN-1:0]          ras_predicted_return,
   input  logic                     ras_valid,
   output logic [XLEN-1:0]          pred_target,
   output logic                     pred_valid,
   output logic                     busy,
   output logic [LOG_PTR_WIDTH:0]   log_count
);
   typedef enum logic {S_IDLE, S_UNWIND} state_t;

   localparam logic [1:0] OP_PUSH = 2'd0;
   localparam logic [1:0] OP_POP  = 2'd1;
   localparam logic [1:0] OP_PNP  = 2'd2;
   localparam logic [LOG_PTR_WIDTH:0] DEPTH_C = (LOG_PTR_WIDTH+1)'(LOG_DEPTH);

   state_t                   state_q, state_d;
   logic [LOG_PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
   logic [LOG_PTR_WIDTH:0]   count_q, count_d, count_after_commit;

   // Speculation log storage; validity is tracked only by head/tail/count
   logic [1:0]               log_op_q    [LOG_DEPTH];
   logic [XLEN-1:0]          log_saved_q [LOG_DEPTH];
   logic                     log_sv_q    [LOG_DEPTH];

   logic idle, accept, commit_ok;

   assign idle               = (state_q == S_IDLE);
   assign dec_ready          = idle & ~flush & (count_q != DEPTH_C);
   assign accept             = dec_valid & dec_ready & (dec_is_call | dec_is_ret);
   assign commit_ok          = idle & commit_valid & (count_q != '0);
   assign count_after_commit = count_q - (LOG_PTR_WIDTH+1)'(commit_ok);
   assign tail_m1            = tail_q - 1'b1;
   assign busy               = ~idle;
   assign log_count          = count_q;
   assign pred_valid         = dec_valid & dec_is_ret & ras_valid & idle;
   assign pred_target        = pred_valid ? ras_predicted_return : '0;

   // State register; reset abandons any unwind in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: flush enters unwind only if entries remain after commit
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (flush && count_after_commit != '0) state_d = S_UNWIND;
         S_UNWIND: if (count_q == (LOG_PTR_WIDTH+1)'(1)) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // RAS commands: forward op on accept, inverse of newest entry in unwind
   always_comb begin
      ras_push        = 1'b0;
      ras_pop         = 1'b0;
      ras_return_addr = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ras_push        = dec_is_call;
               ras_pop         = dec_is_ret;
               ras_return_addr = dec_is_call ? dec_link_addr : '0;
            end
         end
         S_UNWIND: begin
            case (log_op_q[tail_m1])
               OP_PUSH: ras_pop = 1'b1;
               OP_POP: begin
                  ras_push        = log_sv_q[tail_m1];
                  ras_return_addr = log_sv_q[tail_m1] ? log_saved_q[tail_m1] : '0;
               end
               OP_PNP: begin
                  ras_push        = log_sv_q[tail_m1];
                  ras_pop         = log_sv_q[tail_m1];
                  ras_return_addr = log_sv_q[tail_m1] ? log_saved_q[tail_m1] : '0;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Pointer/count next values: commit retires oldest, accept appends, unwind drops newest
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (idle) begin
         head_d  = head_q + LOG_PTR_WIDTH'(commit_ok);
         tail_d  = tail_q + LOG_PTR_WIDTH'(accept);
         count_d = count_after_commit + (LOG_PTR_WIDTH+1)'(accept);
      end else begin
         tail_d  = tail_m1;
         count_d = count_q - 1'b1;
      end
   end

   // Pointer registers; pointers wrap naturally at LOG_DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Log write at tail; saved top/valid captured so pops can be reversed
   always_ff @(posedge clk) begin
      if (accept) begin
         log_op_q[tail_q]    <= (dec_is_call && dec_is_ret) ? OP_PNP :
                                (dec_is_call ? OP_PUSH : OP_POP);
         log_saved_q[tail_q] <= ras_predicted_return;
         log_sv_q[tail_q]    <= ras_valid;
      end
   end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - randomized and directed checks of ras_ctrl against a queue model
module tb_ras_ctrl;
   localparam int RAS_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dec_valid = 1'b0, dec_is_call = 1'b0, dec_is_ret = 1'b0;
   logic [31:0] dec_link_addr = '0;
   logic        dec_ready;
   logic        commit_valid = 1'b0, flush = 1'b0;
   logic        ras_push, ras_pop;
   logic [31:0] ras_return_addr;
   logic [31:0] ras_predicted_return = '0;
   logic        ras_valid = 1'b0;
   logic [31:0] pred_target;
   logic        pred_valid;
   logic        busy;
   logic [3:0]  log_count;

   ras_ctrl #(.XLEN(32), .LOG_DEPTH(8), .LOG_PTR_WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_is_call(dec_is_call), .dec_is_ret(dec_is_ret),
      .dec_link_addr(dec_link_addr), .dec_ready(dec_ready),
      .commit_valid(commit_valid), .flush(flush),
      .ras_push(ras_push), .ras_pop(ras_pop), .ras_return_addr(ras_return_addr),
      .ras_predicted_return(ras_predicted_return), .ras_valid(ras_valid),
      .pred_target(pred_target), .pred_valid(pred_valid),
      .busy(busy), .log_count(log_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 push, 1 pop, 2 push-and-pop
      logic [31:0] saved;
      bit          sv;
   } ent_t;

   ent_t        mlog[$];
   logic [31:0] ras_stk[$];
   bit          unw = 0;
   int          total = 0;
   int          bad = 0;

   logic        s_push, s_pop, s_ready, s_busy, s_pv;
   logic [31:0] s_addr, s_pt;
   logic [3:0]  s_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare every output against the model, advance the model
   task automatic cycle(input bit rst, input bit v, input bit c, input bit r,
                        input logic [31:0] link, input bit cm, input bit fl);
      bit          e_ready, acc, e_push, e_pop, e_pv;
      logic [31:0] e_addr, e_pt;
      int          cnt;
      ent_t        e;
      @(posedge clk); #1;
      reset = rst; dec_valid = v; dec_is_call = c; dec_is_ret = r;
      dec_link_addr = link; commit_valid = cm; flush = fl;
      if (rst) begin
         mlog.delete();
         ras_stk.delete();
         unw = 0;
      end
      ras_valid = (ras_stk.size() > 0);
      ras_predicted_return = ras_valid ? ras_stk[ras_stk.size()-1] : 32'h0;
      @(negedge clk);
      cnt     = mlog.size();
      e_ready = !unw && !fl && cnt < 8;
      acc     = v && e_ready && (c || r);
      e_pv    = v && r && ras_valid && !unw;
      e_pt    = e_pv ? ras_predicted_return : 32'h0;
      e_push  = 0; e_pop = 0; e_addr = 0;
      if (acc) begin
         e_push = c; e_pop = r; e_addr = link;
      end else if (unw) begin
         e = mlog[cnt-1];
         if (e.kind == 0) e_pop = 1;
         else begin
            e_push = e.sv;
            e_pop  = (e.kind == 2) && e.sv;
            e_addr = e.saved;
         end
      end
      s_push = ras_push; s_pop = ras_pop; s_addr = ras_return_addr; s_ready = dec_ready;
      s_busy = busy; s_pv = pred_valid; s_pt = pred_target; s_cnt = log_count;
      chk("dec_ready", s_ready, e_ready);
      chk("ras_push", s_push, e_push);
      chk("ras_pop", s_pop, e_pop);
      if (e_push) chk("ras_return_addr", s_addr, e_addr);
      chk("pred_valid", s_pv, e_pv);
      chk("pred_target", s_pt, e_pt);
      chk("busy", s_busy, unw);
      chk("log_count", s_cnt, cnt);
      if (!rst) begin
         if (unw) begin
            void'(mlog.pop_back());
            if (mlog.size() == 0) unw = 0;
         end else begin
            if (cm && cnt > 0) void'(mlog.pop_front());
            if (acc) begin
               e.kind  = (c && r) ? 2 : (c ? 0 : 1);
               e.saved = ras_predicted_return;
               e.sv    = ras_valid;
               mlog.push_back(e);
            end
            if (fl && mlog.size() > 0) unw = 1;
         end
         if (e_push && e_pop) begin
            if (ras_stk.size() > 0) ras_stk[ras_stk.size()-1] = e_addr;
            else ras_stk.push_back(e_addr);
         end else if (e_push) begin
            ras_stk.push_back(e_addr);
            if (ras_stk.size() > RAS_DEPTH) void'(ras_stk.pop_front());
         end else if (e_pop) begin
            if (ras_stk.size() > 0) void'(ras_stk.pop_back());
         end
      end
   endtask

   task automatic idle_cyc();
      cycle(0, 0, 0, 0, 32'h0, 0, 0);
   endtask

   initial begin
      // reset state
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      chk("lit_reset_ready", s_ready, 1);
      chk("lit_reset_cnt", s_cnt, 0);
      chk("lit_reset_busy", s_busy, 0);

      // two calls then flush: two pop cycles
      cycle(0, 1, 1, 0, 32'h100, 0, 0);
      cycle(0, 1, 1, 0, 32'h200, 0, 0);
      cycle(0, 0, 0, 0, 32'h0, 0, 1);
      chk("lit_t1_flush_ready", s_ready, 0);
      idle_cyc();
      chk("lit_t1_u1_pop", s_pop, 1);
      chk("lit_t1_u1_busy", s_busy, 1);
      chk("lit_t1_u1_cnt", s_cnt, 2);
      idle_cyc();
      chk("lit_t1_u2_pop", s_pop, 1);
      chk("lit_t1_u2_busy", s_busy, 1);
      idle_cyc();
      chk("lit_t1_end_busy", s_busy, 0);
      chk("lit_t1_end_cnt", s_cnt, 0);
      chk("lit_t1_end_ready", s_ready, 1);
      chk("lit_t1_ras_empty", ras_valid, 0);

      // committed call, speculative ret, flush restores 0x100
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      cycle(0, 1, 1, 0, 32'h100, 0, 0);
      cycle(0, 1, 0, 1, 32'h0, 1, 0);
      chk("lit_t2_pred_valid", s_pv, 1);
      chk("lit_t2_pred_target", s_pt, 32'h100);
      cycle(0, 0, 0, 0, 32'h0, 0, 1);
      chk("lit_t2_flush_cnt", s_cnt, 1);
      idle_cyc();
      chk("lit_t2_u_push", s_push, 1);
      chk("lit_t2_u_addr", s_addr, 32'h100);
      chk("lit_t2_u_busy", s_busy, 1);
      idle_cyc();
      chk("lit_t2_end_busy", s_busy, 0);

      // ret on empty RAS, flush: one silent unwind cycle
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      cycle(0, 1, 0, 1, 32'h0, 0, 0);
      chk("lit_t3_pred_valid", s_pv, 0);
      cycle(0, 0, 0, 0, 32'h0, 0, 1);
      idle_cyc();
      chk("lit_t3_u_busy", s_busy, 1);
      chk("lit_t3_u_push", s_push, 0);
      chk("lit_t3_u_pop", s_pop, 0);
      idle_cyc();
      chk("lit_t3_end_busy", s_busy, 0);
      chk("lit_t3_end_ready", s_ready, 1);

      // full log stalls until a commit
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 32'h1000 + 32'(i * 4), 0, 0);
      cycle(0, 1, 1, 0, 32'h2000, 0, 0);
      chk("lit_t4_full_ready", s_ready, 0);
      chk("lit_t4_full_cnt", s_cnt, 8);
      cycle(0, 1, 1, 0, 32'h2000, 1, 0);
      chk("lit_t4_commit_ready", s_ready, 0);
      cycle(0, 1, 1, 0, 32'h2000, 0, 0);
      chk("lit_t4_after_cnt", s_cnt, 7);
      chk("lit_t4_after_ready", s_ready, 1);
      chk("lit_t4_after_push", s_push, 1);

      // tail call over top 0x100, flush restores via push-and-pop
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      cycle(0, 1, 1, 0, 32'h100, 0, 0);
      cycle(0, 1, 1, 1, 32'h300, 0, 0);
      chk("lit_t5_pnp_push", s_push, 1);
      chk("lit_t5_pnp_pop", s_pop, 1);
      chk("lit_t5_pnp_addr", s_addr, 32'h300);
      cycle(0, 0, 0, 0, 32'h0, 0, 1);
      idle_cyc();
      chk("lit_t5_u1_push", s_push, 1);
      chk("lit_t5_u1_pop", s_pop, 1);
      chk("lit_t5_u1_addr", s_addr, 32'h100);
      idle_cyc();
      chk("lit_t5_u2_pop", s_pop, 1);
      chk("lit_t5_u2_push", s_push, 0);

      // reset in second cycle of a 4-entry unwind
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 32'h400 + 32'(i * 4), 0, 0);
      cycle(0, 0, 0, 0, 32'h0, 0, 1);
      idle_cyc();
      chk("lit_t6_u1_busy", s_busy, 1);
      chk("lit_t6_u1_cnt", s_cnt, 4);
      cycle(1, 0, 0, 0, 32'h0, 0, 0);
      chk("lit_t6_rst_busy", s_busy, 0);
      chk("lit_t6_rst_cnt", s_cnt, 0);
      idle_cyc();
      chk("lit_t6_rel_ready", s_ready, 1);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         bit rr, vv, cc, tt, cm, fl;
         rr = ($urandom_range(0, 299) == 0);
         vv = ($urandom_range(0, 9) < 7);
         cc = ($urandom_range(0, 1) == 1);
         tt = ($urandom_range(0, 2) == 0);
         cm = ($urandom_range(0, 9) < 3);
         fl = ($urandom_range(0, 99) < 6);
         cycle(rr, vv, cc, tt, $urandom() & 32'hffff_fffc, cm, fl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
